// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions.
// Holds the controller FSM state encodings and the constants that size its
// counters, so the hazard unit, the controller and any future stage logic
// agree on the same values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DIV_WAIT   = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_TRAP_FLUSH = 2'd3
    } pipe_state_t;

    // Consecutive dmem_busy cycles after which mem_timeout is raised.
    localparam logic [7:0] MEM_TIMEOUT = 8'd255;

    // Last value of the trap-flush counter; the flush therefore lasts two cycles.
    localparam logic [1:0] FLUSH_LAST = 2'd1;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use hazard compare.
// Ports:
//   i_exValid, i_exIsLoad  execute slot holds a real load
//   i_exRd                 execute-stage destination register
//   i_idRs1, i_idRs2       decode-stage source registers
//   i_idUseRs1, i_idUseRs2 decode actually reads the corresponding source
//   o_loadUse              decode depends on the load currently in execute
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_exValid,
    input  logic       i_exIsLoad,
    input  logic [4:0] i_exRd,
    input  logic [4:0] i_idRs1,
    input  logic [4:0] i_idRs2,
    input  logic       i_idUseRs1,
    input  logic       i_idUseRs2,
    output logic       o_loadUse
);

    logic w_rs1Hit;
    logic w_rs2Hit;

    assign w_rs1Hit = i_idUseRs1 && (i_idRs1 == i_exRd);
    assign w_rs2Hit = i_idUseRs2 && (i_idRs2 == i_exRd);

    // x0 is hard-wired zero, so a load into it never creates a dependency.
    assign o_loadUse = i_exValid && i_exIsLoad && (i_exRd != 5'd0) && (w_rs1Hit || w_rs2Hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/bubble controller.
// Ports:
//   clk, rst (synchronous, active-high)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2   decode-stage source operands
//   ex_rd/ex_is_load/ex_valid             execute-stage instruction info
//   ex_redirect                           mispredict resolved in execute
//   div_start/div_done                    multi-cycle divider handshake
//   dmem_busy                             data memory not ready
//   wb_trap                               trap/mret taken at writeback
//   regX_stall / regX_bubble              per-stage pipeline register controls
//   state                                 current FSM state
//   mem_timeout                           one-cycle pulse on the 255th busy cycle
//   stall_cycles                          free-running count of fetch-stall cycles
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_valid,
    input  logic        ex_redirect,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        dmem_busy,
    input  logic        wb_trap,
    output logic        regF_stall,
    output logic        regD_stall,
    output logic        regE_stall,
    output logic        regM_stall,
    output logic        regW_stall,
    output logic        regD_bubble,
    output logic        regE_bubble,
    output logic        regM_bubble,
    output logic        regW_bubble,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    pipe_state_t r_state;
    pipe_state_t r_savedState;
    logic [1:0]  r_flushCnt;
    logic [7:0]  r_waitCnt;
    logic [31:0] r_stallCycles;

    pipe_state_t w_stateNext;
    pipe_state_t w_savedNext;
    pipe_state_t w_effState;
    logic [1:0]  w_flushCntNext;
    logic        w_loadUse;
    logic        w_stallF, w_stallD, w_stallE, w_stallM;
    logic        w_bubD, w_bubE, w_bubM, w_bubW;

    hazard_detect u_hazard (
        .i_exValid  (ex_valid),
        .i_exIsLoad (ex_is_load),
        .i_exRd     (ex_rd),
        .i_idRs1    (id_rs1),
        .i_idRs2    (id_rs2),
        .i_idUseRs1 (id_use_rs1),
        .i_idUseRs2 (id_use_rs2),
        .o_loadUse  (w_loadUse)
    );

    // Once memory releases, the cycle behaves as the state that was interrupted,
    // so a divide in flight keeps stalling without a dead RUN cycle in between.
    assign w_effState = (r_state == ST_MEM_WAIT) ? r_savedState : r_state;

    always_comb begin
        w_stateNext    = r_state;
        w_savedNext    = r_savedState;
        w_flushCntNext = r_flushCnt;
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_bubD   = 1'b0;
        w_bubE   = 1'b0;
        w_bubM   = 1'b0;
        w_bubW   = 1'b0;

        if (rst) begin
            w_bubD = 1'b1;
            w_bubE = 1'b1;
            w_bubM = 1'b1;
            w_bubW = 1'b1;
        end else if (wb_trap) begin
            // A trap abandons any divide or memory wait in progress.
            w_bubD         = 1'b1;
            w_bubE         = 1'b1;
            w_bubM         = 1'b1;
            w_bubW         = 1'b1;
            w_stateNext    = ST_TRAP_FLUSH;
            w_savedNext    = ST_RUN;
            w_flushCntNext = 2'd0;
        end else if (r_state == ST_TRAP_FLUSH) begin
            // The flush runs its fixed length; a busy memory only freezes the
            // front and the memory stage meanwhile.
            w_bubD = 1'b1;
            w_bubE = 1'b1;
            if (dmem_busy) begin
                w_stallF = 1'b1;
                w_stallM = 1'b1;
                w_bubW   = 1'b1;
            end
            if (r_flushCnt == FLUSH_LAST) begin
                w_stateNext    = ST_RUN;
                w_flushCntNext = 2'd0;
            end else begin
                w_flushCntNext = r_flushCnt + 2'd1;
            end
        end else if (dmem_busy) begin
            w_stallF    = 1'b1;
            w_stallD    = 1'b1;
            w_stallE    = 1'b1;
            w_stallM    = 1'b1;
            w_bubW      = 1'b1;
            w_stateNext = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT) begin
                w_savedNext = (r_state == ST_DIV_WAIT) ? ST_DIV_WAIT : ST_RUN;
            end
        end else if (w_effState == ST_DIV_WAIT) begin
            w_stallF    = 1'b1;
            w_stallD    = 1'b1;
            w_stallE    = 1'b1;
            w_bubM      = 1'b1;
            w_stateNext = div_done ? ST_RUN : ST_DIV_WAIT;
        end else begin
            // A divide finishing in its issue cycle never needs to wait.
            w_stateNext = (div_start && !div_done) ? ST_DIV_WAIT : ST_RUN;
            if (ex_redirect) begin
                w_bubD = 1'b1;
                w_bubE = 1'b1;
            end else if (w_loadUse) begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_bubE   = 1'b1;
            end
        end
    end

    // A bubble overrides a stall on the same stage register.
    assign regF_stall  = w_stallF;
    assign regD_stall  = w_stallD && !w_bubD;
    assign regE_stall  = w_stallE && !w_bubE;
    assign regM_stall  = w_stallM && !w_bubM;
    assign regW_stall  = 1'b0;
    assign regD_bubble = w_bubD;
    assign regE_bubble = w_bubE;
    assign regM_bubble = w_bubM;
    assign regW_bubble = w_bubW;

    assign state        = r_state;
    assign stall_cycles = r_stallCycles;

    // Raised during the busy cycle that takes the counter to the limit; the
    // counter then saturates, so the pulse cannot repeat within one busy run.
    assign mem_timeout = !rst && dmem_busy && (r_waitCnt == MEM_TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_savedState  <= ST_RUN;
            r_flushCnt    <= 2'd0;
            r_waitCnt     <= 8'd0;
            r_stallCycles <= 32'd0;
        end else begin
            r_state       <= w_stateNext;
            r_savedState  <= w_savedNext;
            r_flushCnt    <= w_flushCntNext;
            r_stallCycles <= r_stallCycles + {31'd0, regF_stall};
            if (!dmem_busy) begin
                r_waitCnt <= 8'd0;
            end else if (r_waitCnt != MEM_TIMEOUT) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Control outputs are compared as one 9-bit
// vector {F,D,E,M,W stall, D,E,M,W bubble}.
module tb_pipe_ctrl;

    localparam logic [8:0] C_IDLE  = 9'b00000_0000;
    localparam logic [8:0] C_RESET = 9'b00000_1111;
    localparam logic [8:0] C_LU    = 9'b11000_0100;
    localparam logic [8:0] C_RED   = 9'b00000_1100;
    localparam logic [8:0] C_DIV   = 9'b11100_0010;
    localparam logic [8:0] C_MEM   = 9'b11110_0001;
    localparam logic [8:0] C_TRAP  = 9'b00000_1111;
    localparam logic [8:0] C_FLUSH = 9'b00000_1100;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_valid;
    logic        ex_redirect, div_start, div_done, dmem_busy, wb_trap;
    logic        regF_stall, regD_stall, regE_stall, regM_stall, regW_stall;
    logic        regD_bubble, regE_bubble, regM_bubble, regW_bubble;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [8:0]  ctl;

    int total = 0;
    int bad   = 0;

    assign ctl = {regF_stall, regD_stall, regE_stall, regM_stall, regW_stall,
                  regD_bubble, regE_bubble, regM_bubble, regW_bubble};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_valid     (ex_valid),
        .ex_redirect  (ex_redirect),
        .div_start    (div_start),
        .div_done     (div_done),
        .dmem_busy    (dmem_busy),
        .wb_trap      (wb_trap),
        .regF_stall   (regF_stall),
        .regD_stall   (regD_stall),
        .regE_stall   (regE_stall),
        .regM_stall   (regM_stall),
        .regW_stall   (regW_stall),
        .regD_bubble  (regD_bubble),
        .regE_bubble  (regE_bubble),
        .regM_bubble  (regM_bubble),
        .regW_bubble  (regW_bubble),
        .state        (state),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_valid = 1'b0; ex_redirect = 1'b0;
        div_start = 1'b0; div_done = 1'b0; dmem_busy = 1'b0; wb_trap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        advance();
        advance();
        #2;
        total++; if (ctl !== C_RESET) begin bad++; $display("[TB] FAIL reset_ctl got=%b want=%b", ctl, C_RESET); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("[TB] FAIL reset_stallcnt got=%0d want=0", stall_cycles); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b want=0", mem_timeout); end
        advance();
        rst = 1'b0;
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("[TB] FAIL run_idle got=%b want=%b", ctl, C_IDLE); end
        advance();
    endtask

    task automatic test_load_use();
        logic [31:0] sc0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #2;
        sc0 = stall_cycles;
        total++; if (ctl !== C_LU) begin bad++; $display("[TB] FAIL lu_rs1 got=%b want=%b", ctl, C_LU); end
        advance();
        ex_valid = 1'b0;
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("[TB] FAIL lu_after got=%b want=%b", ctl, C_IDLE); end
        total++; if (stall_cycles !== sc0 + 32'd1) begin bad++; $display("[TB] FAIL lu_stallcnt got=%0d want=%0d", stall_cycles, sc0 + 32'd1); end
        ex_valid = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("[TB] FAIL lu_x0 got=%b want=%b", ctl, C_IDLE); end
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd7; ex_rd = 5'd7;
        #2;
        total++; if (ctl !== C_LU) begin bad++; $display("[TB] FAIL lu_rs2 got=%b want=%b", ctl, C_LU); end
        id_use_rs2 = 1'b0;
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("[TB] FAIL lu_unused got=%b want=%b", ctl, C_IDLE); end
        id_use_rs2 = 1'b1; ex_is_load = 1'b0;
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("[TB] FAIL lu_notload got=%b want=%b", ctl, C_IDLE); end
        clearInputs();
        advance();
    endtask

    task automatic test_redirect();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        ex_redirect = 1'b1;
        #2;
        total++; if (ctl !== C_RED) begin bad++; $display("[TB] FAIL redirect_lu got=%b want=%b", ctl, C_RED); end
        advance();
        clearInputs();
        #2;
        total++; if (ctl !== C_IDLE || state !== 2'd0) begin bad++; $display("[TB] FAIL redirect_after got=%b/%0d want=%b/0", ctl, state, C_IDLE); end
        advance();
    endtask

    task automatic test_div();
        logic [31:0] sc0;
        div_start = 1'b1;
        #2;
        total++; if (ctl !== C_IDLE || state !== 2'd0) begin bad++; $display("[TB] FAIL div_issue got=%b/%0d want=%b/0", ctl, state, C_IDLE); end
        sc0 = stall_cycles;
        advance();
        div_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            div_done = (i == 6);
            #2;
            total++; if (state !== 2'd1 || ctl !== C_DIV) begin bad++; $display("[TB] FAIL div_wait%0d got=%0d/%b want=1/%b", i, state, ctl, C_DIV); end
            advance();
        end
        div_done = 1'b0;
        #2;
        total++; if (state !== 2'd0 || ctl !== C_IDLE) begin bad++; $display("[TB] FAIL div_end got=%0d/%b want=0/%b", state, ctl, C_IDLE); end
        total++; if (stall_cycles !== sc0 + 32'd6) begin bad++; $display("[TB] FAIL div_stallcnt got=%0d want=%0d", stall_cycles, sc0 + 32'd6); end
        div_start = 1'b1; div_done = 1'b1;
        advance();
        clearInputs();
        #2;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL div_sameCycle got=%0d want=0", state); end
        advance();
    endtask

    task automatic test_mem_timeout();
        logic [31:0] sc0;
        int pulses;
        pulses = 0;
        sc0 = stall_cycles;
        for (int i = 1; i <= 300; i++) begin
            dmem_busy = 1'b1;
            #2;
            if (mem_timeout === 1'b1) pulses++;
            total++; if (mem_timeout !== (i == 255)) begin bad++; $display("[TB] FAIL mem_pulse%0d got=%b want=%b", i, mem_timeout, (i == 255)); end
            total++; if (ctl !== C_MEM || (i > 1 && state !== 2'd2)) begin bad++; $display("[TB] FAIL mem_wait%0d got=%0d/%b want=2/%b", i, state, ctl, C_MEM); end
            advance();
        end
        dmem_busy = 1'b0;
        #2;
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL mem_pulseCount got=%0d want=1", pulses); end
        total++; if (stall_cycles !== sc0 + 32'd300) begin bad++; $display("[TB] FAIL mem_stallcnt got=%0d want=%0d", stall_cycles, sc0 + 32'd300); end
        total++; if (state !== 2'd2 || ctl !== C_IDLE) begin bad++; $display("[TB] FAIL mem_release got=%0d/%b want=2/%b", state, ctl, C_IDLE); end
        advance();
        #2;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL mem_return got=%0d want=0", state); end
        pulses = 0;
        for (int i = 1; i <= 255; i++) begin
            dmem_busy = 1'b1;
            #2;
            if (mem_timeout === 1'b1) pulses++;
            advance();
        end
        dmem_busy = 1'b0;
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL mem_rearm got=%0d want=1", pulses); end
        advance();
    endtask

    task automatic test_trap_in_div();
        div_start = 1'b1;
        advance();
        div_start = 1'b0;
        advance();
        wb_trap = 1'b1;
        #2;
        total++; if (state !== 2'd1 || ctl !== C_TRAP) begin bad++; $display("[TB] FAIL trap_cycle got=%0d/%b want=1/%b", state, ctl, C_TRAP); end
        advance();
        wb_trap = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            #2;
            total++; if (state !== 2'd3 || ctl !== C_FLUSH) begin bad++; $display("[TB] FAIL trap_flush%0d got=%0d/%b want=3/%b", i, state, ctl, C_FLUSH); end
            advance();
        end
        #2;
        total++; if (state !== 2'd0 || ctl !== C_IDLE) begin bad++; $display("[TB] FAIL trap_end got=%0d/%b want=0/%b", state, ctl, C_IDLE); end
        advance();
    endtask

    task automatic test_mem_in_div();
        div_start = 1'b1;
        advance();
        div_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            dmem_busy = 1'b1;
            #2;
            total++; if (ctl !== C_MEM || state !== ((i == 1) ? 2'd1 : 2'd2)) begin bad++; $display("[TB] FAIL memdiv_busy%0d got=%0d/%b want=%0d/%b", i, state, ctl, (i == 1) ? 1 : 2, C_MEM); end
            advance();
        end
        dmem_busy = 1'b0;
        #2;
        total++; if (state !== 2'd2 || ctl !== C_DIV) begin bad++; $display("[TB] FAIL memdiv_release got=%0d/%b want=2/%b", state, ctl, C_DIV); end
        advance();
        #2;
        total++; if (state !== 2'd1 || ctl !== C_DIV) begin bad++; $display("[TB] FAIL memdiv_resume got=%0d/%b want=1/%b", state, ctl, C_DIV); end
        div_done = 1'b1;
        advance();
        div_done = 1'b0;
        #2;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL memdiv_done got=%0d want=0", state); end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        div_start = 1'b1;
        advance();
        div_start = 1'b0;
        rst = 1'b1;
        #2;
        total++; if (ctl !== C_RESET) begin bad++; $display("[TB] FAIL rstwait_ctl got=%b want=%b", ctl, C_RESET); end
        advance();
        rst = 1'b0;
        #2;
        total++; if (state !== 2'd0 || stall_cycles !== 32'd0) begin bad++; $display("[TB] FAIL rstwait_state got=%0d/%0d want=0/0", state, stall_cycles); end
        advance();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_div();
        test_mem_timeout();
        test_trap_in_div();
        test_mem_in_div();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: id_rs1, id_rs2  in  5 each  decode-stage source registers; id_use_rs1, id_use_rs2  in  1 each  source-used flags.
REQ-003 SHALL have ports: ex_rd  in  5  execute-stage destination; ex_is_load  in  1  execute holds a load; ex_valid  in  1  execute slot holds a real instruction.
REQ-004 SHALL have ports: ex_redirect  in  1  branch/jump mispredict resolved in execute; div_start  in  1  divide issued from execute; div_done  in  1  divider result ready.
REQ-005 SHALL have ports: dmem_busy  in  1  data memory not ready; wb_trap  in  1  trap/mret taken at writeback.
REQ-006 SHALL have outputs regF_stall, regD_stall, regE_stall, regM_stall, regW_stall  1 each; regD_bubble, regE_bubble, regM_bubble, regW_bubble  1 each.
REQ-007 SHALL have outputs state  2  current FSM state; mem_timeout  1  one-cycle pulse; stall_cycles  32  count of cycles with regF_stall=1.

Function
REQ-008 FSM states SHALL be RUN=0, DIV_WAIT=1, MEM_WAIT=2, TRAP_FLUSH=3; state is registered, and all stall/bubble outputs are combinational from state and current inputs.
REQ-009 Priority each cycle SHALL be wb_trap > dmem_busy > DIV_WAIT > ex_redirect > load-use.
REQ-010 wb_trap in any state SHALL assert regD/E/M/W_bubble that cycle and move to TRAP_FLUSH; TRAP_FLUSH SHALL last exactly 2 cycles (2-bit counter), asserting regD_bubble and regE_bubble, then go to RUN.
REQ-011 dmem_busy (no trap) SHALL assert regF/D/E/M_stall and regW_bubble, and enter or remain in MEM_WAIT; when dmem_busy falls, the state SHALL return to the saved prior state (RUN or DIV_WAIT).
REQ-012 An 8-bit wait counter SHALL count consecutive dmem_busy cycles; on reaching 255, mem_timeout SHALL pulse for one cycle and the counter SHALL hold at 255 until dmem_busy falls, then clear to 0.
REQ-013 div_start in RUN SHALL move to DIV_WAIT next cycle; DIV_WAIT SHALL assert regF/D/E_stall and regM_bubble until div_done, with return to RUN the cycle after div_done.
REQ-014 div_start and div_done in the same cycle SHALL not enter DIV_WAIT.
REQ-015 ex_redirect in RUN (no higher event) SHALL assert regD_bubble and regE_bubble for that cycle only, with no stall.
REQ-016 Load-use SHALL be detected when ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); it SHALL assert regF_stall, regD_stall and regE_bubble for one cycle.
REQ-017 ex_redirect and load-use together SHALL produce redirect behaviour only.
REQ-018 A stage SHALL never see stall and bubble simultaneously; bubble wins.
REQ-019 stall_cycles SHALL increment every cycle regF_stall=1 and wrap from 2^32-1 to 0.

Reset
REQ-020 rst SHALL force state=RUN, both counters=0, saved state=RUN, mem_timeout=0, stall_cycles=0.
REQ-021 While rst=1, all bubble outputs SHALL be 1 and all stall outputs 0; rst mid-DIV_WAIT/MEM_WAIT SHALL abandon the wait.

Structure
REQ-022 The FSM state encodings and the timeout constant 255 SHALL reside in the shared pipeline package.
REQ-023 The hazard compare (REQ-016) SHALL be a sub-module hazard_detect, purely combinational; everything else stays in pipe_ctrl.

Verification
REQ-024 Stimulus ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle of regF_stall=regD_stall=regE_bubble=1; same with ex_rd=0 -> none.
REQ-025 Stimulus div_start, then div_done 6 cycles later -> 6 cycles of state=1 with F/D/E stall and regM_bubble, then state=0.
REQ-026 Stimulus dmem_busy held 300 cycles -> mem_timeout pulses once at the 255th busy cycle; state=2 throughout; stall_cycles +300.
REQ-027 Stimulus wb_trap during DIV_WAIT -> D/E/M/W bubble that cycle, then 2 cycles TRAP_FLUSH, then RUN (division abandoned).
REQ-028 Stimulus ex_redirect with simultaneous load-use hit -> regD_bubble=regE_bubble=1, all stalls 0.
REQ-029 Stimulus dmem_busy during DIV_WAIT for 3 cycles -> state=2, then returns to state=1 while div_done remains low.
